// File: rtl/lfsr_pkg.sv
// Shared LFSR constants, checker state encoding and step function.
// Used by the generator and the checker so the polynomials cannot diverge.
package lfsr_pkg;

    localparam int              WIDTH  = 8;
    localparam logic [WIDTH-1:0] TAP_UP = 8'h63;
    localparam logic [WIDTH-1:0] TAP_DN = 8'hB1;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // XNOR feedback: up shifts right with feedback into the MSB,
    // down shifts left with feedback into the LSB.
    function automatic logic [WIDTH-1:0] lfsr_step(
        input logic [WIDTH-1:0] c,
        input logic             dir
    );
        if (dir)
            return {~^(c & TAP_UP), c[WIDTH-1:1]};
        else
            return {c[WIDTH-2:0], ~^(c & TAP_DN)};
    endfunction

endpackage

// File: rtl/lfsr_sequence_checker_if.sv
// Sequence word bus between LFSR generator (master) and checker (slave).
// Signals: in_valid, in_data[WIDTH], in_dir (1 = up, 0 = down).
interface lfsr_sequence_checker_if;
    import lfsr_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;

    modport master (output in_valid, output in_data, output in_dir);
    modport slave  (input  in_valid, input  in_data, input  in_dir);

endinterface

// File: rtl/lfsr_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, reset, inc, clr in; cnt[CNT_W] out.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Self-synchronising checker for the up/down XNOR LFSR sequence.
// Ports: clk, reset, bus (slave: in_valid/in_data/in_dir), clear_stats in;
//        locked, err_pulse, err_count[CNT_W], word_count[CNT_W] out.
module lfsr_sequence_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    lfsr_sequence_checker_if.slave  bus,
    input  logic                    clear_stats,
    output logic                    locked,
    output logic                    err_pulse,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        word_count
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_expected;
    logic             r_dir;
    logic [3:0]       r_match;
    logic [3:0]       r_miss;
    logic             r_err_pulse;

    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_step_data;
    logic [WIDTH-1:0] w_step_exp;
    logic             w_hit;
    logic             w_dir_chg;
    logic             w_lockup;
    logic             w_live;
    logic             w_err_inc;

    assign w_seed      = lfsr_step(bus.in_data, bus.in_dir);
    assign w_step_data = lfsr_step(bus.in_data, r_dir);
    assign w_step_exp  = lfsr_step(r_expected, r_dir);
    assign w_hit       = (bus.in_data == r_expected);
    assign w_dir_chg   = (bus.in_dir != r_dir);
    assign w_lockup    = (bus.in_data == {WIDTH{1'b1}});

    // A direction change is never a compared word.
    assign w_live    = bus.in_valid && (r_state == LOCKED) && !w_dir_chg;
    assign w_err_inc = w_live && !w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_expected  <= '0;
            r_dir       <= 1'b0;
            r_match     <= '0;
            r_miss      <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (bus.in_valid) begin
                case (r_state)
                    HUNT: begin
                        // All-ones is the XNOR lockup word: it seeds nothing.
                        if (!w_lockup) begin
                            r_expected <= w_seed;
                            r_dir      <= bus.in_dir;
                            r_match    <= '0;
                            r_state    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (w_dir_chg) begin
                            r_state <= HUNT;
                        end else begin
                            r_expected <= w_step_data;
                            if (w_hit) begin
                                r_match <= r_match + 4'd1;
                                if (r_match + 4'd1 == LOCK_N) begin
                                    r_state <= LOCKED;
                                    r_miss  <= '0;
                                end
                            end else begin
                                r_match <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_dir_chg) begin
                            r_state <= HUNT;
                        end else begin
                            // Free-run the predictor; data never reseeds here.
                            r_expected <= w_step_exp;
                            if (w_hit) begin
                                r_miss <= '0;
                            end else begin
                                r_err_pulse <= 1'b1;
                                r_miss      <= r_miss + 4'd1;
                                if (r_miss + 4'd1 == LOSS_N)
                                    r_state <= HUNT;
                            end
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err_pulse;

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_err_inc),
        .clr   (clear_stats),
        .cnt   (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_live),
        .clr   (clear_stats),
        .cnt   (word_count)
    );

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Directed bench for lfsr_sequence_checker: lock, errors, loss, lockup,
// direction change, saturation, clear and reset.
module tb_lfsr_sequence_checker;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_stats = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] word_count;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int base;
    logic [7:0] exp_w;

    lfsr_sequence_checker_if bus ();

    lfsr_sequence_checker #(
        .LOCK_COUNT (4),
        .LOSS_COUNT (4),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_stats (clear_stats),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) pulse_cnt++;

    function automatic logic [7:0] nxt(input logic [7:0] c, input logic d);
        logic [7:0] tu;
        logic [7:0] td;
        tu = 8'h63;
        td = 8'hB1;
        if (d) return {~^(c & tu), c[7:1]};
        return {c[6:0], ~^(c & td)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic dir,
                       input logic clr = 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dir   = dir;
        clear_stats  = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clear_stats  = 1'b0;
    endtask

    task automatic idle(input logic clr = 1'b0);
        clear_stats = clr;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // 00,80,C0,60,B0 up: lock exactly after the fifth word.
    task automatic lock_up(input string tag);
        logic [7:0] s [5];
        s = '{8'h00, 8'h80, 8'hC0, 8'h60, 8'hB0};
        for (int i = 0; i < 5; i++) begin
            put(s[i], 1'b1);
            chk(tag, locked, (i == 4) ? 1 : 0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dir   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_ecnt", err_count, 0);
        chk("rst_wcnt", word_count, 0);

        // 1: lock and first counted word
        lock_up("t1_lock");
        chk("t1_ecnt", err_count, 0);
        chk("t1_wcnt0", word_count, 0);
        put(8'h58, 1'b1);
        chk("t1_wcnt1", word_count, 1);
        chk("t1_pulse", err_pulse, 0);

        // 2: single corrupted word 2C -> 2D
        put(8'h2D, 1'b1);
        chk("t2_pulse", err_pulse, 1);
        chk("t2_ecnt", err_count, 1);
        chk("t2_locked", locked, 1);
        put(8'h16, 1'b1);
        chk("t2_pulse0", err_pulse, 0);
        chk("t2_ecnt1", err_count, 1);
        chk("t2_wcnt", word_count, 3);
        put(8'h0B, 1'b1);
        put(8'h85, 1'b1);
        chk("t2_wcnt5", word_count, 5);
        idle(1'b1);
        chk("t2_clr_e", err_count, 0);
        chk("t2_clr_w", word_count, 0);

        // 3: four garbage words drop lock (predicted 42,A1,D0,68)
        put(8'h11, 1'b1);
        chk("t3_p1", err_pulse, 1);
        put(8'h22, 1'b1);
        put(8'h33, 1'b1);
        chk("t3_lk3", locked, 1);
        put(8'h44, 1'b1);
        chk("t3_p4", err_pulse, 1);
        chk("t3_lost", locked, 0);
        chk("t3_ecnt", err_count, 4);
        chk("t3_wcnt", word_count, 4);
        idle();
        chk("t3_p_end", err_pulse, 0);
        lock_up("t3_relock");

        // 4: lockup words ignored, VERIFY reseeds silently
        do_reset();
        chk("t4_rst", locked, 0);
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) put(8'hFF, 1'b1);
        chk("t4_ff", locked, 0);
        put(8'h00, 1'b1);
        put(8'h80, 1'b1);
        put(8'hC0, 1'b1);
        put(8'h55, 1'b1);
        lock_up("t4_lock");
        chk("t4_pulses", pulse_cnt - base, 0);
        chk("t4_ecnt", err_count, 0);

        // 5: direction flip while locked, relock on down sequence
        base = pulse_cnt;
        put(8'h58, 1'b0);
        chk("t5_hunt", locked, 0);
        chk("t5_wcnt", word_count, 0);
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        put(8'h05, 1'b0);
        put(8'h0A, 1'b0);
        chk("t5_nolock", locked, 0);
        put(8'h15, 1'b0);
        chk("t5_lock", locked, 1);
        put(8'h2B, 1'b0);
        chk("t5_wcnt1", word_count, 1);
        chk("t5_pulses", pulse_cnt - base, 0);
        chk("t5_ecnt", err_count, 0);

        // 6: saturation, clear-vs-error, reset while locked
        do_reset();
        lock_up("t6_lock");
        exp_w = 8'h58;
        for (int g = 0; g < 86; g++) begin
            for (int k = 0; k < 3; k++) begin
                put(exp_w ^ 8'h01, 1'b1);
                exp_w = nxt(exp_w, 1'b1);
            end
            put(exp_w, 1'b1);
            exp_w = nxt(exp_w, 1'b1);
        end
        chk("t6_esat", err_count, 8'hFF);
        chk("t6_wsat", word_count, 8'hFF);
        chk("t6_locked", locked, 1);
        put(exp_w ^ 8'h01, 1'b1, 1'b1);
        exp_w = nxt(exp_w, 1'b1);
        chk("t6_clr_e", err_count, 0);
        chk("t6_clr_w", word_count, 0);
        chk("t6_clr_p", err_pulse, 1);
        put(exp_w, 1'b1);
        exp_w = nxt(exp_w, 1'b1);
        chk("t6_w1", word_count, 1);
        reset = 1'b1;
        put(exp_w ^ 8'h01, 1'b1);
        reset = 1'b0;
        chk("t6_r_lk", locked, 0);
        chk("t6_r_p", err_pulse, 0);
        chk("t6_r_e", err_count, 0);
        chk("t6_r_w", word_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
